refresh_timer: RTL and testbench



---
 rtl/refresh_timer.sv | 113 +++++++++++
 tb/tb_refresh_timer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/refresh_timer.sv
// rtl/refresh_timer.sv - DRAM refresh request pacer and CBR completion monitor
//
// Paces refresh demand from a free-running interval counter, keeps a count of
// owed refreshes (debt), and retires one owed refresh each time a CAS-before-RAS
// cycle is observed on the DRAM pins.
//
// Ports:
//   CLK     in  system clock, all state on the rising edge
//   nRESET  in  asynchronous active-low reset
//   nRAS    in  DRAM /RAS pin (observed, same clock domain)
//   nCAS    in  DRAM /CAS pin (observed, same clock domain)
//   RefReq  out refresh requested (to RAM controller RefReqIn)
//   RefUrg  out refresh urgent (to RAM controller RefUrgIn)
//   Overrun out sticky: a tick arrived while debt was already saturated

module refresh_timer #(
  parameter int unsigned PERIOD    = 250,
  parameter int unsigned URG_DELAY = 64,
  parameter int unsigned MAXDEBT   = 3
) (
  input  logic CLK,
  input  logic nRESET,
  input  logic nRAS,
  input  logic nCAS,
  output logic RefReq,
  output logic RefUrg,
  output logic Overrun
);

  localparam logic [9:0] IC_LAST  = 10'(PERIOD - 1);
  localparam logic [1:0] DEBT_MAX = 2'(MAXDEBT);
  localparam logic [7:0] URG_TH   = 8'(URG_DELAY);

  logic [9:0] ic_q, ic_d;
  logic [1:0] debt_q, debt_d;
  logic [7:0] age_q, age_d;
  logic       hold_q, hold_d;
  logic       rasq_q, casq_q;
  logic       ovr_q, ovr_d;
  logic       req_q, req_d;
  logic       urg_q, urg_d;

  logic       tick;
  logic       cbr;
  logic       accept;

  always_comb begin
    tick = (ic_q == IC_LAST);
    ic_d = tick ? 10'd0 : ic_q + 10'd1;

    // /CAS falling while /RAS was still high at the previous edge.
    cbr    = casq_q && !nCAS && rasq_q;
    accept = cbr && (debt_q != 2'd0);

    debt_d = debt_q;
    ovr_d  = ovr_q;
    if (tick && !cbr) begin
      if (debt_q == DEBT_MAX) begin
        ovr_d = 1'b1;
      end else begin
        debt_d = debt_q + 2'd1;
      end
    end else if (!tick && accept) begin
      debt_d = debt_q - 2'd1;
    end

    // Age measures edges a refresh has been owed since it became owed or since
    // the last retire; it starts at zero on the edge that first creates debt so
    // escalation happens URG_DELAY edges after RefReq rises.
    if ((debt_d == 2'd0) || accept || (debt_q == 2'd0)) begin
      age_d = 8'd0;
    end else if (age_q != 8'hFF) begin
      age_d = age_q + 8'd1;
    end else begin
      age_d = age_q;
    end

    // One-cycle gap after a retire lets the controller's done latch clear.
    hold_d = accept;

    req_d = !hold_d && (debt_d != 2'd0);
    urg_d = req_d && ((age_d >= URG_TH) || (debt_d >= 2'd2));
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      ic_q   <= 10'd0;
      debt_q <= 2'd0;
      age_q  <= 8'd0;
      hold_q <= 1'b0;
      rasq_q <= 1'b1;
      casq_q <= 1'b1;
      ovr_q  <= 1'b0;
      req_q  <= 1'b0;
      urg_q  <= 1'b0;
    end else begin
      ic_q   <= ic_d;
      debt_q <= debt_d;
      age_q  <= age_d;
      hold_q <= hold_d;
      rasq_q <= nRAS;
      casq_q <= nCAS;
      ovr_q  <= ovr_d;
      req_q  <= req_d;
      urg_q  <= urg_d;
    end
  end

  assign RefReq  = req_q;
  assign RefUrg  = urg_q;
  assign Overrun = ovr_q;

endmodule

// File: tb/tb_refresh_timer.sv
// tb/tb_refresh_timer.sv - self-checking bench for refresh_timer
module tb_refresh_timer;

  localparam int P = 16;
  localparam int U = 8;
  localparam int M = 3;

  logic CLK    = 1'b0;
  logic nRESET = 1'b0;
  logic nRAS   = 1'b1;
  logic nCAS   = 1'b1;
  logic RefReq, RefUrg, Overrun;

  int checks = 0;
  int errors = 0;

  // Reference model: edges since reset, owed refreshes, edge at which the
  // current wait began, and last sampled pins.
  int m_n, m_debt, m_start;
  bit m_hold, m_ovr, m_pras, m_pcas;
  bit e_req, e_urg;

  refresh_timer #(.PERIOD(P), .URG_DELAY(U), .MAXDEBT(M)) dut (
    .CLK    (CLK),
    .nRESET (nRESET),
    .nRAS   (nRAS),
    .nCAS   (nCAS),
    .RefReq (RefReq),
    .RefUrg (RefUrg),
    .Overrun(Overrun)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic a, input logic e);
    checks++;
    assert (a === e) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b (t=%0t)", tag, a, e, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_debt = 0; m_start = 0;
    m_hold = 0; m_ovr = 0; m_pras = 1; m_pcas = 1;
    e_req = 0; e_urg = 0;
  endtask

  task automatic model_step(input bit ras, input bit cas);
    bit tick, cbr, acc;
    int old;
    m_n++;
    tick = (m_n % P) == 0;
    cbr  = m_pcas && !cas && m_pras;
    old  = m_debt;
    acc  = cbr && (old > 0);
    if (tick && !cbr) begin
      if (m_debt == M) m_ovr = 1;
      else m_debt++;
    end else if (cbr && !tick && m_debt > 0) begin
      m_debt--;
    end
    if (acc || (old == 0 && m_debt > 0)) m_start = m_n;
    m_hold = acc;
    m_pras = ras;
    m_pcas = cas;
    e_req = !m_hold && (m_debt > 0);
    e_urg = e_req && (((m_n - m_start) >= U) || (m_debt >= 2));
  endtask

  task automatic cyc(input bit ras, input bit cas);
    nRAS = ras;
    nCAS = cas;
    @(posedge CLK);
    model_step(ras, cas);
    @(negedge CLK);
    chk("model_req", RefReq, e_req);
    chk("model_urg", RefUrg, e_urg);
    chk("model_ovr", Overrun, m_ovr);
  endtask

  // Pulse reset between edges; caller is just after a falling edge.
  task automatic async_reset(input string tag);
    nRESET = 1'b0;
    #2;
    chk({tag, "_req"}, RefReq, 1'b0);
    chk({tag, "_urg"}, RefUrg, 1'b0);
    chk({tag, "_ovr"}, Overrun, 1'b0);
    model_reset();
    #1;
    nRESET = 1'b1;
  endtask

  initial begin
    int r;
    model_reset();
    repeat (3) @(negedge CLK);
    chk("reset_req", RefReq, 1'b0);
    chk("reset_urg", RefUrg, 1'b0);
    chk("reset_ovr", Overrun, 1'b0);
    nRESET = 1'b1;

    // First tick lands on edge 16.
    repeat (15) cyc(1, 1);
    chk("pre_tick_req", RefReq, 1'b0);
    cyc(1, 1);
    chk("first_tick_req", RefReq, 1'b1);
    chk("first_tick_urg", RefUrg, 1'b0);

    // Escalation exactly 8 edges after RefReq rose.
    repeat (7) cyc(1, 1);
    chk("urg_edge23", RefUrg, 1'b0);
    cyc(1, 1);
    chk("urg_edge24", RefUrg, 1'b1);
    repeat (8) cyc(1, 1);
    chk("second_tick_urg", RefUrg, 1'b1);

    // CBR retire at edge 33.
    cyc(1, 0);
    chk("cbr_e_req", RefReq, 1'b0);
    chk("cbr_e_urg", RefUrg, 1'b0);
    cyc(0, 1);
    chk("cbr_e1_req", RefReq, 1'b1);
    chk("cbr_e1_urg", RefUrg, 1'b0);
    cyc(0, 1);
    cyc(1, 1);

    // Normal RAS-then-CAS access must not retire anything.
    cyc(0, 1);
    cyc(0, 0);
    chk("normal_req", RefReq, 1'b1);
    cyc(1, 1);
    chk("normal_req2", RefReq, 1'b1);

    // Saturate debt and overrun at edge 80.
    while (m_n < 79) cyc(1, 1);
    chk("pre_overrun", Overrun, 1'b0);
    cyc(1, 1);
    chk("overrun_set", Overrun, 1'b1);
    chk("overrun_urg", RefUrg, 1'b1);

    // CBR coinciding with tick at edge 96.
    while (m_n < 95) cyc(1, 1);
    cyc(1, 0);
    chk("simul_ovr", Overrun, 1'b1);
    cyc(0, 1);
    chk("simul_req", RefReq, 1'b1);
    chk("simul_urg", RefUrg, 1'b1);
    cyc(1, 1);

    // Asynchronous reset mid-operation, then tick 16 edges after release.
    async_reset("async");
    repeat (15) cyc(1, 1);
    chk("post_reset_pre_tick", RefReq, 1'b0);
    cyc(1, 1);
    chk("post_reset_tick", RefReq, 1'b1);

    // Randomised pin activity against the model.
    repeat (700) begin
      r = $urandom_range(0, 199);
      if (r == 0) begin
        async_reset("rand_reset");
      end else if (r < 110) begin
        cyc(1, 1);
      end else if (r < 140) begin
        cyc(1, 0);
        cyc(0, 0);
        cyc(1, 1);
      end else if (r < 170) begin
        cyc(0, 1);
        cyc(0, 0);
        cyc(1, 1);
      end else begin
        cyc(1'($urandom), 1'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
